// File: rtl/btn_conditioner.sv
// Four independent pushbutton conditioners: 2-flop synchronizer, debounce,
// press/release pulses, auto-repeat and a long-press flag per button.
module btn_conditioner #(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_rep,
  output logic [3:0] btn_long
);

  localparam int MAX_AB  = (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
  localparam int MAX_CYC = (MAX_AB > RPT_PERIOD) ? MAX_AB : RPT_PERIOD;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DB_CNT     = CW'(DB_CYCLES);
  localparam logic [CW-1:0] DELAY_CNT  = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_CNT = CW'(RPT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, REL_DB} state_t;

  logic [3:0] sync_meta;
  logic [3:0] sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two synchronizer stages distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          was_rep, was_rep_nx;
    logic          level_q, press_q, release_q, rep_q, long_q;
    logic          level_nx, press_nx, release_nx, rep_nx, long_nx;

    assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        was_rep   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rep_q     <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        was_rep   <= was_rep_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        rep_q     <= rep_nx;
        long_q    <= long_nx;
      end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      was_rep_nx = was_rep;
      level_nx   = level_q;
      long_nx    = long_q;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      rep_nx     = 1'b0;
      unique case (state)
        IDLE: begin
          if (sync[i]) begin
            state_nx = PRESS_DB;
            cnt_nx   = CW'(1);
          end
        end
        PRESS_DB: begin
          if (!sync[i]) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == DB_CNT) begin
            state_nx   = HELD;
            cnt_nx     = '0;
            was_rep_nx = 1'b0;
            level_nx   = 1'b1;
            press_nx   = 1'b1;
            rep_nx     = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        HELD: begin
          if (!sync[i]) begin
            state_nx = REL_DB;
            cnt_nx   = CW'(1);
          end else if (cnt == DELAY_CNT) begin
            state_nx   = REPEAT;
            cnt_nx     = '0;
            was_rep_nx = 1'b1;
            long_nx    = 1'b1;
            rep_nx     = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        REPEAT: begin
          if (!sync[i]) begin
            state_nx = REL_DB;
            cnt_nx   = CW'(1);
          end else if (cnt == PERIOD_CNT) begin
            cnt_nx = '0;
            rep_nx = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        REL_DB: begin
          // A bounce back high resumes the hold phase it interrupted.
          if (sync[i]) begin
            state_nx = was_rep ? REPEAT : HELD;
            cnt_nx   = '0;
          end else if (cnt == DB_CNT) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            level_nx   = 1'b0;
            long_nx    = 1'b0;
            release_nx = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_rep[i]     = rep_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomized bench for btn_conditioner with an elapsed-time
// reference model of debounce, repeat and long-press behaviour.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_rep, btn_long;

  btn_conditioner #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_rep    (btn_rep),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted level flips after DB+1 consecutive opposite
  // synchronized samples; repeats are timed from an anchor edge.
  int         now;
  int         run    [4];
  int         anchor [4];
  bit         lvl    [4];
  bit         lng    [4];
  logic [3:0] raw_d1, raw_d2;
  logic [3:0] e_level, e_press, e_release, e_rep, e_long;

  // Observation tallies for the directed scenarios.
  int first_press_edge [4];
  int n_press [4];
  int n_rel   [4];
  int n_rep   [4];
  int n_all_press;
  bit any_bit1;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    now = -1;
    raw_d1 = '0;
    raw_d2 = '0;
    for (int i = 0; i < 4; i++) begin
      run[i] = 0; anchor[i] = 0; lvl[i] = 1'b0; lng[i] = 1'b0;
    end
    e_level = '0; e_press = '0; e_release = '0; e_rep = '0; e_long = '0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    int e;
    now++;
    s = raw_d2;
    raw_d2 = raw_d1;
    raw_d1 = btn_raw;
    e_press = '0; e_release = '0; e_rep = '0;
    for (int i = 0; i < 4; i++) begin
      if (!lvl[i]) begin
        run[i] = s[i] ? run[i] + 1 : 0;
        if (run[i] == DB + 1) begin
          lvl[i] = 1'b1; lng[i] = 1'b0; run[i] = 0; anchor[i] = now;
          e_press[i] = 1'b1; e_rep[i] = 1'b1;
        end
      end else if (!s[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          lvl[i] = 1'b0; lng[i] = 1'b0; run[i] = 0;
          e_release[i] = 1'b1;
        end
      end else if (run[i] > 0) begin
        run[i] = 0;
        anchor[i] = now;
      end else begin
        e = now - anchor[i];
        if (!lng[i]) begin
          if (e == RD) begin
            lng[i] = 1'b1; anchor[i] = now; e_rep[i] = 1'b1;
          end
        end else if (e > 0 && e % RP == 0) begin
          e_rep[i] = 1'b1;
        end
      end
      e_level[i] = lvl[i];
      e_long[i]  = lng[i];
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) begin
      first_press_edge[i] = -1; n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0;
    end
    n_all_press = 0;
    any_bit1 = 1'b0;
  endtask

  task automatic check_outputs();
    check("level",   btn_level,   e_level);
    check("press",   btn_press,   e_press);
    check("release", btn_release, e_release);
    check("rep",     btn_rep,     e_rep);
    check("long",    btn_long,    e_long);
  endtask

  // Drive one raw value for one clock, advance the model and compare at negedge.
  task automatic step(input logic [3:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < 4; i++) begin
      if (btn_press[i] && first_press_edge[i] < 0) first_press_edge[i] = now;
      n_press[i] += int'(btn_press[i]);
      n_rel[i]   += int'(btn_release[i]);
      n_rep[i]   += int'(btn_rep[i]);
    end
    if (btn_press == 4'b1111) n_all_press++;
    if ({btn_level[1], btn_press[1], btn_release[1], btn_rep[1], btn_long[1]} != '0)
      any_bit1 = 1'b1;
  endtask

  task automatic steps(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw);
  endtask

  // Called at a negedge: assert reset, verify the asynchronous clear, release.
  task automatic pulse_reset(input logic [3:0] raw);
    btn_raw = raw;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hold [4];
    logic [3:0] rv;

    rst = 1'b1;
    btn_raw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Clean press on bit 0: accepted at edge 6, no repeat within 10 cycles.
    clear_obs();
    steps(4'b0001, 10);
    check("p0_edge", 4'(first_press_edge[0]), 4'd6);
    check("p0_rep_cnt", 4'(n_rep[0]), 4'd1);
    steps(4'b0000, 10);

    // Short glitch on bit 1 is ignored.
    model_reset(); pulse_reset('0); clear_obs();
    steps(4'b0010, 3);
    steps(4'b0000, 12);
    check("glitch_b1", {3'b0, any_bit1}, 4'b0000);

    // Long hold on bit 2: six repeats inside 60 accepted cycles.
    model_reset(); pulse_reset('0); clear_obs();
    steps(4'b0100, 64);
    steps(4'b0000, 10);
    check("b2_rep_cnt", 4'(n_rep[2]), 4'd6);

    // Bit 3 release with a bounce inside the release debounce.
    model_reset(); pulse_reset('0); clear_obs();
    steps(4'b1000, 30);
    steps(4'b0000, 2);
    steps(4'b1000, 2);
    check("b3_no_rel", 4'(n_rel[3]), 4'd0);
    steps(4'b0000, 10);
    check("b3_rel_cnt", 4'(n_rel[3]), 4'd1);

    // Simultaneous presses on all four bits.
    model_reset(); pulse_reset('0); clear_obs();
    steps(4'b1111, 10);
    check("all_press_cnt", 4'(n_all_press), 4'd1);
    check("all_press_edge", 4'(first_press_edge[3]), 4'd6);
    steps(4'b0000, 10);

    // Reset while bit 0 is auto-repeating: fresh press, no release.
    model_reset(); pulse_reset('0); clear_obs();
    steps(4'b0001, 40);
    pulse_reset(4'b0001);
    clear_obs();
    steps(4'b0001, 10);
    check("rst_repress_edge", 4'(first_press_edge[0]), 4'd6);
    check("rst_no_release", 4'(n_rel[0]), 4'd0);
    steps(4'b0000, 10);

    // Randomized bouncing buttons with occasional resets.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          rv[i] = ~rv[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 45);
        end
        hold[i]--;
      end
      if ($urandom_range(0, 599) == 0) pulse_reset(rv);
      step(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
